// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 4-digit hex display.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry n is the pattern for hex digit n.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex_display_arbiter_hex_to_seg.sv
// Combinational nibble to active-low 7-segment pattern (dp held off).
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_arbiter.sv
// Digit-scan controller plus round-robin req/grant arbiter sharing one
// 4-digit 7-segment display between two 16-bit sources.
module hex_display_arbiter
    import display_pkg::*;
#(
    parameter int SCAN_DIV    = 400,
    parameter int HOLD_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic        blank_lz,
    output logic [1:0]  grant,
    output logic [3:0]  anodes,
    output logic [7:0]  seg
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);

    logic [SW-1:0] scan_cnt_reg;
    logic [1:0]    digit_reg;
    logic [FW-1:0] frame_cnt_reg;
    state_t        state_reg;
    logic          last_reg;
    logic [15:0]   shown_reg;

    logic tick, frame_end;
    logic owner, own_req, other_req, hold_done;
    logic load, next_src, release_now;

    assign tick      = (scan_cnt_reg == SCAN_LAST);
    assign frame_end = tick && (digit_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            digit_reg    <= 2'd0;
        end else if (tick) begin
            scan_cnt_reg <= '0;
            digit_reg    <= digit_reg + 2'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SW'(1);
        end
    end

    // owner: 0 for SHOW0, 1 for SHOW1 (meaningless in IDLE)
    assign owner     = (state_reg == SHOW1);
    assign own_req   = req[owner];
    assign other_req = req[~owner];
    assign hold_done = (frame_cnt_reg == HOLD_LAST);

    // IDLE grants on any clk; an owner only yields at a frame boundary.
    assign load = (state_reg == IDLE) ? (req != 2'b00)
                                      : (frame_end && other_req && (!own_req || hold_done));
    assign next_src = (state_reg == IDLE) ? ((req == 2'b11) ? ~last_reg : req[1])
                                          : ~owner;
    assign release_now = (state_reg != IDLE) && frame_end && !own_req && !other_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant         <= 2'b00;
            shown_reg     <= 16'h0000;
            frame_cnt_reg <= '0;
            last_reg      <= 1'b1;
        end else if (load) begin
            state_reg     <= next_src ? SHOW1 : SHOW0;
            grant         <= next_src ? 2'b10 : 2'b01;
            shown_reg     <= next_src ? data1 : data0;
            frame_cnt_reg <= '0;
            last_reg      <= next_src;
        end else if (release_now) begin
            state_reg <= IDLE;
            grant     <= 2'b00;
        end else if ((state_reg != IDLE) && frame_end) begin
            shown_reg <= owner ? data1 : data0;
            if (!hold_done) begin
                frame_cnt_reg <= frame_cnt_reg + FW'(1);
            end
        end
    end

    // zero_above[d]: nibble d and every higher nibble are zero
    logic [3:0] zero_above;
    assign zero_above[0] = 1'b0;
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
        assign zero_above[gi] = (shown_reg[15:4*gi] == '0);
    end

    logic [3:0] nibble;
    logic [7:0] digit_seg;
    logic       blank_digit;

    assign nibble      = shown_reg[{digit_reg, 2'b00} +: 4];
    assign blank_digit = blank_lz && zero_above[digit_reg];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (digit_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes <= AN_OFF;
            seg    <= SEG_OFF;
        end else if ((state_reg == IDLE) || blank_digit) begin
            anodes <= AN_OFF;
            seg    <= SEG_OFF;
        end else begin
            anodes <= ~(4'b0001 << digit_reg);
            seg    <= digit_seg;
        end
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: table vectors, hand sequences for arbitration
// corners, and a randomized run against a frame-level reference model.
module tb_hex_display_arbiter;

    localparam int SD = 4;
    localparam int HF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] data0 = 16'h0;
    logic [15:0] data1 = 16'h0;
    logic        blank_lz = 1'b0;
    logic [1:0]  grant;
    logic [3:0]  anodes;
    logic [7:0]  seg;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;

    hex_display_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .blank_lz (blank_lz),
        .grant    (grant),
        .anodes   (anodes),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; leaves the DUT out of reset at a negedge with edge_cnt=0.
    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic adv_to(input int k);
        while (edge_cnt < k) begin
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    // ---------------- reference model (frame-level, elapsed-cycle based) -----
    int          m_owner;
    int          m_last;
    int          m_frames;
    logic [15:0] m_shown;
    logic [1:0]  e_grant;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 1;
        m_frames = 0;
        m_shown  = 16'h0;
    endtask

    task automatic give_to(input int src);
        m_owner  = src;
        m_last   = src;
        m_frames = 0;
        m_shown  = (src == 1) ? data1 : data0;
    endtask

    // Edge k after reset release: digit on display = ((k-1)/4)%4, frame ends on
    // every 16th edge. Outputs reflect the model state before this edge.
    task automatic model_step(input int k);
        int          d;
        bit          fe;
        bit          own;
        bit          oth;
        logic [15:0] upper;
        d  = ((k - 1) / SD) % 4;
        fe = ((k - 1) % (4 * SD)) == (4 * SD - 1);
        if (m_owner < 0) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
        end else begin
            upper = m_shown >> (4 * d);
            if (blank_lz && d != 0 && upper == 16'h0) begin
                e_an  = 4'hF;
                e_seg = 8'hFF;
            end else begin
                e_an  = 4'hF ^ (4'b0001 << d);
                e_seg = seg_of(upper[3:0]);
            end
        end
        if (m_owner < 0) begin
            if (req == 2'b11)      give_to(1 - m_last);
            else if (req == 2'b01) give_to(0);
            else if (req == 2'b10) give_to(1);
        end else if (fe) begin
            own = req[m_owner];
            oth = req[1 - m_owner];
            if (!own && oth)                            give_to(1 - m_owner);
            else if (!own)                              m_owner = -1;
            else if (oth && m_frames >= HF - 1)         give_to(1 - m_owner);
            else begin
                if (m_frames < HF - 1) m_frames++;
                m_shown = (m_owner == 1) ? data1 : data0;
            end
        end
        e_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    endtask

    // ---------------- table vectors: one full frame of source 0 ------------
    typedef struct packed {
        logic [15:0] data;
        logic        blz;
        logic [15:0] an_all;   // digit d anode pattern at [4d+:4]
        logic [31:0] seg_all;  // digit d segments at [8d+:8]
    } vec_t;

    vec_t vecs [7];

    initial begin
        int bad0;
        vecs[0] = '{16'h12AF, 1'b0, 16'h7BDE, 32'hF9A4888E};
        vecs[1] = '{16'h0030, 1'b1, 16'hFFDE, 32'hFFFFB0C0};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFFE, 32'hFFFFFFC0};
        vecs[3] = '{16'h0000, 1'b0, 16'h7BDE, 32'hC0C0C0C0};
        vecs[4] = '{16'h0F00, 1'b1, 16'hFBDE, 32'hFF8EC0C0};
        vecs[5] = '{16'h1111, 1'b1, 16'h7BDE, 32'hF9F9F9F9};
        vecs[6] = '{16'h9B5D, 1'b0, 16'h7BDE, 32'h908392A1};

        @(negedge clk);
        apply_reset();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_anodes", 32'(anodes), 32'hF);
        chk("reset_seg", 32'(seg), 32'hFF);

        for (int i = 0; i < 7; i++) begin
            bad0 = bad;
            apply_reset();
            data0    = vecs[i].data;
            blank_lz = vecs[i].blz;
            req      = 2'b01;
            adv_to(1);
            chk("vec_grant", 32'(grant), 32'h1);
            for (int d = 0; d < 4; d++) begin
                adv_to(4 * (d + 1));
                chk("vec_anodes", 32'(anodes), 32'(vecs[i].an_all[4*d +: 4]));
                chk("vec_seg", 32'(seg), 32'(vecs[i].seg_all[8*d +: 8]));
            end
            $display("vector %0d data0=%h blank_lz=%0d errors=%0d", i, vecs[i].data, vecs[i].blz, bad - bad0);
        end

        // Round-robin from IDLE after reset: last=1 so source 0 goes first.
        bad0 = bad;
        apply_reset();
        blank_lz = 1'b0;
        data0 = 16'h1234;
        data1 = 16'hABCD;
        req = 2'b11;
        adv_to(1);  chk("rr_first", 32'(grant), 32'h1);
        adv_to(31); chk("rr_hold0", 32'(grant), 32'h1);
        adv_to(32); chk("rr_switch1", 32'(grant), 32'h2);
        adv_to(36); chk("rr_data1_seg", 32'(seg), 32'hA1);
        adv_to(63); chk("rr_hold1", 32'(grant), 32'h2);
        adv_to(64); chk("rr_switch0", 32'(grant), 32'h1);
        $display("sequence round_robin errors=%0d", bad - bad0);

        // Release mid-frame: takes effect only at the frame boundary.
        bad0 = bad;
        apply_reset();
        req = 2'b10;
        adv_to(19);
        req = 2'b00;
        adv_to(31); chk("rel_hold", 32'(grant), 32'h2);
        adv_to(32); chk("rel_idle", 32'(grant), 32'h0);
        adv_to(33); chk("rel_anodes", 32'(anodes), 32'hF);
        chk("rel_seg", 32'(seg), 32'hFF);
        $display("sequence release errors=%0d", bad - bad0);

        // Data change at digit 1 must not tear the frame in progress.
        bad0 = bad;
        apply_reset();
        data0 = 16'h1111;
        req = 2'b01;
        adv_to(21);
        data0 = 16'h2222;
        adv_to(28); chk("tear_d2", 32'(seg), 32'hF9);
        adv_to(32); chk("tear_d3", 32'(seg), 32'hF9);
        adv_to(36); chk("next_d0", 32'(seg), 32'hA4);
        adv_to(44); chk("next_d2", 32'(seg), 32'hA4);
        adv_to(48); chk("next_d3", 32'(seg), 32'hA4);
        $display("sequence no_tear errors=%0d", bad - bad0);

        // Asynchronous reset in the middle of a SHOW0 frame.
        bad0 = bad;
        apply_reset();
        data0 = 16'h12AF;
        req = 2'b01;
        adv_to(22);
        chk("pre_rst_grant", 32'(grant), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_anodes", 32'(anodes), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'hFF);
        chk("async_rst_grant", 32'(grant), 32'h0);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        edge_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            adv_to(k);
            if (k % 5 == 0) begin
                chk("idle_anodes", 32'(anodes), 32'hF);
                chk("idle_seg", 32'(seg), 32'hFF);
                chk("idle_grant", 32'(grant), 32'h0);
            end
        end
        $display("sequence async_reset errors=%0d", bad - bad0);

        // Randomized run against the reference model.
        begin
            logic [15:0] masks [4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
            for (int batch = 0; batch < 4; batch++) begin
                bad0 = bad;
                apply_reset();
                model_reset();
                data0 = 16'($urandom);
                data1 = 16'($urandom);
                for (int k = 1; k <= 1000; k++) begin
                    if ($urandom_range(0, 15) == 0) req = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) data0 = 16'($urandom) & masks[$urandom_range(0, 3)];
                    if ($urandom_range(0, 7) == 0) data1 = 16'($urandom) & masks[$urandom_range(0, 3)];
                    if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
                    @(posedge clk);
                    model_step(k);
                    @(negedge clk);
                    chk("rnd_grant", 32'(grant), 32'(e_grant));
                    chk("rnd_anodes", 32'(anodes), 32'(e_an));
                    chk("rnd_seg", 32'(seg), 32'(e_seg));
                end
                $display("random batch %0d cycles=1000 errors=%0d", batch, bad - bad0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
